// File: rtl/count_event_pkg.sv
// Shared types and default widths for the count event monitor.
package count_event_pkg;

    localparam int CW_DEF = 8;
    localparam int HW_DEF = 16;
    localparam int EW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/count_edge_detect.sv
// Remembers the last valid counter sample and flags a fresh arrival at
// match_val and an all-ones -> zero rollover, both combinationally.
module count_edge_detect #(
    parameter int CW = 8
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic [CW-1:0] count_in,
    input  logic          count_valid,
    input  logic [CW-1:0] match_val,
    output logic          match_edge,
    output logic          wrap_edge
);

    logic [CW-1:0] prev_q;
    logic          prev_vld_q;

    // Capture the sample on every valid update; hold otherwise.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (count_valid) begin
            prev_q     <= count_in;
            prev_vld_q <= 1'b1;
        end
    end

    // A value parked at match_val only counts on arrival; the very first
    // sample after reset has no history and may match.
    always_comb begin
        match_edge = count_valid && (count_in == match_val) &&
                     (!prev_vld_q || (prev_q != match_val));
        wrap_edge  = count_valid && prev_vld_q &&
                     (prev_q == {CW{1'b1}}) && (count_in == '0);
    end

endmodule

// File: rtl/count_event_monitor.sv
// Counter event monitor: registered match/wrap trigger pulses, match
// rate limiting through an IDLE/ARMED/HOLDOFF state machine, and a
// saturating match tally.
// Optional build macro COUNT_EVENT_MONITOR_STICKY_EN adds a sticky[1:0]
// output (bit0 = match seen, bit1 = wrap seen) held until clear.
//
// state   | meaning
// IDLE    | arm low; no match detection
// ARMED   | waiting for a match edge
// HOLDOFF | match recently fired; further matches ignored until timer expires
module count_event_monitor
    import count_event_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int HW = HW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    input  logic [CW-1:0] count_in,
    input  logic          count_valid,
    input  logic          arm,
    input  logic [CW-1:0] match_val,
    input  logic [HW-1:0] holdoff,
    input  logic          clear,
    output logic          trig_match,
    output logic          trig_wrap,
    output logic [EW-1:0] event_count,
    output logic [1:0]    state,
    output logic          busy
`ifdef COUNT_EVENT_MONITOR_STICKY_EN
    ,
    output logic [1:0]    sticky
`endif
);

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [EW-1:0] ev_cnt_q, ev_cnt_d;
    logic          trig_match_q, trig_wrap_q, busy_q;
    logic          fire;
    logic          match_edge, wrap_edge;

    count_edge_detect #(.CW(CW)) u_edge (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .count_in   (count_in),
        .count_valid(count_valid),
        .match_val  (match_val),
        .match_edge (match_edge),
        .wrap_edge  (wrap_edge)
    );

    // Next state, holdoff timer and match qualification; dropping arm
    // overrides everything, including a match in the same cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fire    = 1'b0;
        if (!arm) begin
            state_d = IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (match_edge) begin
                        fire = 1'b1;
                        if (holdoff != '0) begin
                            hold_d  = holdoff;
                            state_d = HOLDOFF;
                        end
                    end
                end
                HOLDOFF: begin
                    if (hold_q <= HW'(1)) begin
                        hold_d  = '0;
                        state_d = ARMED;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Saturating match tally; clear beats a same-cycle increment.
    always_comb begin
        ev_cnt_d = ev_cnt_q;
        if (clear) begin
            ev_cnt_d = '0;
        end else if (fire && (ev_cnt_q != {EW{1'b1}})) begin
            ev_cnt_d = ev_cnt_q + EW'(1);
        end
    end

    // State, timer, tally and the registered trigger/busy outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            ev_cnt_q     <= '0;
            trig_match_q <= 1'b0;
            trig_wrap_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            ev_cnt_q     <= ev_cnt_d;
            trig_match_q <= fire;
            trig_wrap_q  <= wrap_edge;
            busy_q       <= (state_d == HOLDOFF);
        end
    end

    assign trig_match  = trig_match_q;
    assign trig_wrap   = trig_wrap_q;
    assign event_count = ev_cnt_q;
    assign state       = state_q;
    assign busy        = busy_q;

`ifdef COUNT_EVENT_MONITOR_STICKY_EN
    logic [1:0] sticky_q, sticky_d;

    // New events win over clear so nothing slips through unseen.
    always_comb begin
        sticky_d = (clear ? 2'b00 : sticky_q) | {wrap_edge, fire};
    end

    // Sticky flags rise together with the trigger pulses.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: a behavioural reference model predicts
// every registered output per cycle into a scoreboard queue, a monitor
// pops and compares after each rising edge, and each scenario task adds
// directed end-of-scenario checks.
module tb_count_event_monitor;
    import count_event_pkg::*;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic [7:0]  count_in;
    logic        count_valid;
    logic        arm;
    logic [7:0]  match_val;
    logic [15:0] holdoff;
    logic        clear;
    logic        trig_match, trig_wrap, busy;
    logic [15:0] event_count;
    logic [1:0]  state;
`ifdef COUNT_EVENT_MONITOR_STICKY_EN
    logic [1:0]  sticky;
`endif

    count_event_monitor #(.CW(8), .HW(16), .EW(16)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .count_in   (count_in),
        .count_valid(count_valid),
        .arm        (arm),
        .match_val  (match_val),
        .holdoff    (holdoff),
        .clear      (clear),
        .trig_match (trig_match),
        .trig_wrap  (trig_wrap),
        .event_count(event_count),
        .state      (state),
        .busy       (busy)
`ifdef COUNT_EVENT_MONITOR_STICKY_EN
        ,
        .sticky     (sticky)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        tm;
        logic        tw;
        logic [15:0] ev;
        logic [1:0]  st;
        logic        busy;
        logic [1:0]  stk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;

    int total = 0;
    int bad = 0;
    int n_match = 0;
    int n_wrap = 0;
    int n_busy = 0;

    // reference model state
    logic [7:0]  m_prev;
    logic        m_vld;
    logic [1:0]  m_state;
    logic [15:0] m_hold;
    logic [15:0] m_ev;
    logic [1:0]  m_stk;

    task automatic model_reset();
        m_prev = 8'h00; m_vld = 1'b0; m_state = 2'd0;
        m_hold = 16'h0; m_ev = 16'h0; m_stk = 2'b00;
    endtask

    // Drive one cycle of stimulus, predict the outputs after the next
    // rising edge, and queue the prediction.
    task automatic drive(input logic cv, input logic [7:0] cin, input logic clr);
        exp_t e;
        logic me, we, fire;
        logic [1:0] ns;
        logic [15:0] nh;
        count_valid = cv;
        count_in    = cin;
        clear       = clr;
        me   = cv && (cin == match_val) && (!m_vld || (m_prev != match_val));
        we   = cv && m_vld && (m_prev == 8'hFF) && (cin == 8'h00);
        fire = 1'b0;
        ns   = m_state;
        nh   = m_hold;
        if (!arm) begin
            ns = 2'd0; nh = 16'h0;
        end else if (m_state == 2'd0) begin
            ns = 2'd1;
        end else if (m_state == 2'd1) begin
            if (me) begin
                fire = 1'b1;
                if (holdoff != 16'h0) begin
                    ns = 2'd2; nh = holdoff;
                end
            end
        end else if (m_state == 2'd2) begin
            nh = m_hold - 16'h1;
            if (m_hold == 16'h1) ns = 2'd1;
        end else begin
            ns = 2'd0; nh = 16'h0;
        end
        if (clr) m_ev = 16'h0;
        else if (fire && m_ev != 16'hFFFF) m_ev = m_ev + 16'h1;
        m_stk   = (clr ? 2'b00 : m_stk) | {we, fire};
        m_state = ns;
        m_hold  = nh;
        if (cv) begin
            m_prev = cin; m_vld = 1'b1;
        end
        e.tm = fire; e.tw = we; e.ev = m_ev; e.st = ns;
        e.busy = (ns == 2'd2); e.stk = m_stk;
        sb.push_back(e);
        @(posedge sys_clk);
        @(negedge sys_clk);
        clear       = 1'b0;
        count_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare queued predictions just after each edge.
    always @(posedge sys_clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            total++;
            if (trig_match !== mon_exp.tm) begin
                bad++;
                $display("FAIL sb_trig_match t=%0t got=%b exp=%b", $time, trig_match, mon_exp.tm);
            end
            total++;
            if (trig_wrap !== mon_exp.tw) begin
                bad++;
                $display("FAIL sb_trig_wrap t=%0t got=%b exp=%b", $time, trig_wrap, mon_exp.tw);
            end
            total++;
            if (event_count !== mon_exp.ev) begin
                bad++;
                $display("FAIL sb_event_count t=%0t got=%h exp=%h", $time, event_count, mon_exp.ev);
            end
            total++;
            if (state !== mon_exp.st) begin
                bad++;
                $display("FAIL sb_state t=%0t got=%0d exp=%0d", $time, state, mon_exp.st);
            end
            total++;
            if (busy !== mon_exp.busy) begin
                bad++;
                $display("FAIL sb_busy t=%0t got=%b exp=%b", $time, busy, mon_exp.busy);
            end
`ifdef COUNT_EVENT_MONITOR_STICKY_EN
            total++;
            if (sticky !== mon_exp.stk) begin
                bad++;
                $display("FAIL sb_sticky t=%0t got=%b exp=%b", $time, sticky, mon_exp.stk);
            end
`endif
            n_match += int'(trig_match);
            n_wrap  += int'(trig_wrap);
            n_busy  += int'(busy);
        end
    end

    task automatic test_reset();
        #3;
        total++;
        if ({trig_match, trig_wrap, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_pulses got=%b exp=000", {trig_match, trig_wrap, busy});
        end
        total++;
        if (event_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_event_count got=%h exp=0000", event_count);
        end
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d exp=0", state);
        end
        @(negedge sys_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_match();
        arm = 1'b1; match_val = 8'h05; holdoff = 16'd0;
        drive(1'b0, 8'h00, 1'b0);
        n_match = 0;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(i), 1'b0);
        total++;
        if (n_match !== 1) begin
            bad++;
            $display("FAIL single_match_pulses got=%0d exp=1", n_match);
        end
        total++;
        if (event_count !== 16'd1) begin
            bad++;
            $display("FAIL single_match_count got=%0d exp=1", event_count);
        end
    endtask

    task automatic test_hold_value();
        drive(1'b0, 8'h00, 1'b1);
        n_match = 0;
        for (int i = 0; i < 10; i++) drive(1'b1, 8'h05, 1'b0);
        total++;
        if (n_match !== 1) begin
            bad++;
            $display("FAIL hold_value_pulses got=%0d exp=1", n_match);
        end
        total++;
        if (event_count !== 16'd1) begin
            bad++;
            $display("FAIL hold_value_count got=%0d exp=1", event_count);
        end
    endtask

    task automatic test_holdoff();
        holdoff = 16'd4;
        drive(1'b1, 8'h06, 1'b1);
        n_match = 0; n_busy = 0;
        for (int i = 0; i < 6; i++) drive(1'b1, (i % 2 == 0) ? 8'h05 : 8'h06, 1'b0);
        total++;
        if (n_busy !== 4) begin
            bad++;
            $display("FAIL holdoff_busy_cycles got=%0d exp=4", n_busy);
        end
        total++;
        if (n_match !== 1) begin
            bad++;
            $display("FAIL holdoff_ignored got=%0d exp=1", n_match);
        end
        drive(1'b1, 8'h05, 1'b0);
        total++;
        if (n_match !== 2 || event_count !== 16'd2) begin
            bad++;
            $display("FAIL holdoff_rearm got=%0d/%0d exp=2/2", n_match, event_count);
        end
    endtask

    task automatic test_wrap();
        arm = 1'b0;
        n_match = 0; n_wrap = 0;
        drive(1'b1, 8'hFE, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        total++;
        if (n_wrap !== 1 || n_match !== 0) begin
            bad++;
            $display("FAIL wrap_up got=%0d/%0d exp=1/0", n_wrap, n_match);
        end
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        total++;
        if (n_wrap !== 2) begin
            bad++;
            $display("FAIL wrap_down_and_gap got=%0d exp=2", n_wrap);
        end
    endtask

    task automatic test_saturate();
        arm = 1'b1; holdoff = 16'd0;
        force dut.ev_cnt_q = 16'hFFFE;
        m_ev = 16'hFFFE;
        drive(1'b0, 8'h00, 1'b0);
        release dut.ev_cnt_q;
        drive(1'b1, 8'h05, 1'b0);
        drive(1'b1, 8'h06, 1'b0);
        drive(1'b1, 8'h05, 1'b0);
        total++;
        if (event_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL saturate got=%h exp=ffff", event_count);
        end
        n_match = 0;
        drive(1'b1, 8'h06, 1'b0);
        drive(1'b1, 8'h05, 1'b1);
        total++;
        if (event_count !== 16'h0 || n_match !== 1) begin
            bad++;
            $display("FAIL clear_vs_incr got=%h/%0d exp=0000/1", event_count, n_match);
        end
    endtask

    task automatic test_arm_drop();
        holdoff = 16'd8;
        drive(1'b1, 8'h06, 1'b1);
        drive(1'b1, 8'h05, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h06, 1'b0);
        arm = 1'b0;
        drive(1'b1, 8'h06, 1'b0);
        total++;
        if (state !== 2'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL arm_drop got=%0d/%b exp=0/0", state, busy);
        end
        arm = 1'b1;
        drive(1'b1, 8'h06, 1'b0);
        drive(1'b1, 8'h06, 1'b0);
        n_match = 0;
        arm = 1'b0;
        drive(1'b1, 8'h05, 1'b0);
        total++;
        if (n_match !== 0) begin
            bad++;
            $display("FAIL arm_priority got=%0d exp=0", n_match);
        end
    endtask

    task automatic test_async_reset();
        arm = 1'b1; holdoff = 16'd8;
        drive(1'b1, 8'h06, 1'b0);
        drive(1'b1, 8'h05, 1'b0);
        drive(1'b1, 8'h05, 1'b0);
        drive(1'b1, 8'h05, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({trig_match, trig_wrap, busy, state} !== 5'b0 || event_count !== 16'h0) begin
            bad++;
            $display("FAIL async_reset got=%b%b%b/%0d/%h exp=000/0/0000",
                     trig_match, trig_wrap, busy, state, event_count);
        end
        @(negedge sys_clk);
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        n_match = 0;
        drive(1'b1, 8'h05, 1'b0);
        total++;
        if (n_match !== 1) begin
            bad++;
            $display("FAIL post_reset_match got=%0d exp=1", n_match);
        end
    endtask

    initial begin
        reset_n = 1'b0; count_in = 8'h00; count_valid = 1'b0; arm = 1'b0;
        match_val = 8'h05; holdoff = 16'h0; clear = 1'b0;
        model_reset();
        test_reset();
        test_single_match();
        test_hold_value();
        test_holdoff();
        test_wrap();
        test_saturate();
        test_arm_drop();
        test_async_reset();
        @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream consumer of a free-running counter value, e.g. an 8-bit up/down counter with a divided-clock autocount.
- Watches each counter update and raises one-cycle trigger pulses on a programmable match and on max->0 wrap.
- Match triggers are rate-limited by an armed/holdoff state machine, and matches are tallied in a saturating event counter.
- Outputs feed TriggerOut/WireOut endpoints on sys_clk.

Parameters:
- CW, 8: counter value width.
- HW, 16: holdoff counter width (sys_clk cycles).
- EW, 16: event counter width.

Ports:
- sys_clk  in  1  block clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- count_in  in  CW  observed counter value.
- count_valid  in  1  count_in is sampled this cycle. Assert on every counter update, or tie high.
- arm  in  1  level enable for match detection.
- match_val  in  CW  compare value, quasi-static.
- holdoff  in  HW  re-arm delay after a match trigger, in cycles.
- clear  in  1  one-cycle pulse; zeroes event_count and sticky.
- trig_match  out  1  one-cycle pulse on a qualified match.
- trig_wrap  out  1  one-cycle pulse on a wrap (all-ones -> 0).
- event_count  out  EW  saturating count of trig_match pulses.
- state  out  2  current FSM state encoding.
- busy  out  1  high while in HOLDOFF.

Behaviour:
- Reset values: all outputs 0; state = IDLE; internal prev = 0; prev_vld = 0; holdoff counter = 0.
- Sample register:
  - On count_valid: prev <= count_in and prev_vld <= 1.
  - Without count_valid: prev and prev_vld hold.
- match_edge = count_valid && count_in == match_val && (!prev_vld || prev != match_val).
  - A value that stays at match_val across repeated valid samples fires only once.
- wrap_edge = count_valid && prev_vld && prev == all-ones && count_in == 0.
  - Counting down from 0 to all-ones is not a wrap.
- Latency: trig_match and trig_wrap are registered, high exactly one cycle, in the cycle after the qualifying count_valid.
- trig_wrap is independent of arm and state.
- FSM states: IDLE = 0, ARMED = 1, HOLDOFF = 2; encoding 3 is unused and recovers to IDLE.
  - IDLE: when arm = 1, go to ARMED next cycle. No match detection in IDLE.
  - ARMED, match_edge with holdoff != 0: pulse trig_match, increment event_count, load holdoff counter with holdoff, go to HOLDOFF.
  - ARMED, match_edge with holdoff == 0: pulse trig_match and stay in ARMED.
  - HOLDOFF: decrement the holdoff counter each sys_clk cycle. When it equals 1, go to ARMED next cycle, so HOLDOFF lasts exactly holdoff cycles.
  - In HOLDOFF, match_edge is ignored: no pulse and no increment.
  - arm = 0 in any state: go to IDLE next cycle and zero the holdoff counter. arm has priority over a match in the same cycle, so that match produces no pulse.
- event_count:
  - Saturates at all-ones; no wrap.
  - clear zeroes it next cycle. clear wins over a simultaneous increment.
  - clear does not affect the FSM.
- busy = (state == HOLDOFF), registered with the state.
- Asynchronous reset mid-holdoff: immediately returns to the reset values; prev_vld = 0, so the first sample after reset can match.

Optional Feature:
- Macro COUNT_EVENT_MONITOR_STICKY_EN.
- When defined:
  - Adds output sticky [1:0]: bit0 set by trig_match, bit1 set by trig_wrap.
  - Bits are set in the same cycle as the pulse and hold until clear or reset.
  - Set wins over a simultaneous clear, so no event is lost.
- When undefined: the port is absent and no sticky logic is built; all other behaviour is identical.

Decomposition:
- Package count_event_pkg holds:
  - the state_t enum (IDLE = 2'd0, ARMED = 2'd1, HOLDOFF = 2'd2);
  - default widths CW_DEF = 8, HW_DEF = 16, EW_DEF = 16.
- One natural sub-module, count_edge_detect, parameterised by CW:
  - owns prev and prev_vld;
  - produces match_edge and wrap_edge combinationally.
- The FSM, holdoff counter, event counter and trigger registers stay in the top module.

Test Plan:
- Reset then arm = 1, match_val = 8'h05, holdoff = 0; step count 0..7 with count_valid each cycle -> exactly one trig_match, in the cycle after the count_in = 5 sample; event_count = 1.
- Hold count_in = 5 with count_valid high for 10 cycles, ARMED -> one trig_match only; event_count = 1.
- holdoff = 4; count_in toggles 5, 6, 5, 6 on consecutive cycles -> first 5 fires; busy high 4 cycles; the 5 at +2 is ignored; the next 5 after busy falls fires.
- count_in FE -> FF -> 00 with arm = 0 -> trig_wrap one cycle after the 00 sample and no trig_match; count_in 00 -> FF -> no trig_wrap.
- Preload event_count = FFFF (EW = 16) and match again -> stays FFFF. Assert clear in the same cycle as an increment -> event_count = 0.
- In HOLDOFF with the counter at 3, drop arm -> state IDLE next cycle and busy = 0. Separately, assert reset_n low mid-holdoff -> all outputs 0 immediately, with no sys_clk edge required.
